dff_bank_arbiter: RTL and testbench

// Round-robin arbiter sharing one WIDTH-bit D-flip-flop storage register

---
 rtl/dff_bank_arbiter_if.sv | 29 ++
 rtl/dff_bank_arbiter.sv | 132 +++++++++++++
 tb/tb_dff_bank_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dff_bank_arbiter_if.sv
// Bundle between the requesters and the shared storage-register arbiter.
// No latency of its own: signals only, grouped for port hookup.
// Requesters drive req/lock/d_in (master); the arbiter answers with gnt/ack/q (slave).
interface dff_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] d_in;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [IW-1:0]          owner;
    logic                   busy;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       q_bar;

    modport master (
        output req, lock, d_in,
        input  gnt, ack, owner, busy, q, q_bar
    );

    modport slave (
        input  req, lock, d_in,
        output gnt, ack, owner, busy, q, q_bar
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter owning one WIDTH-bit storage register shared by N_REQ requesters, with lock/hold.
// Latency: winner's d_in lands on q, and gnt/ack/owner update, at the grant edge (one cycle after request).
// Backpressure: losers and non-owners simply get no ack and must keep req high to retry.
module dff_bank_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    dff_bank_arbiter_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_REQ - 1);

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    ptr_q,   ptr_d;
    logic [HW-1:0]    hold_q,  hold_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [N_REQ-1:0] ack_q,   ack_d;
    logic [IW-1:0]    owner_q, owner_d;

    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    ptr_nxt;
    logic [WIDTH-1:0] din_arr [N_REQ];

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Slice the flat data bus into one word per requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_din
        assign din_arr[i] = bus.d_in[i*WIDTH +: WIDTH];
    end

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % N_REQ);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        ptr_nxt = (win_idx == IDX_LAST) ? '0 : win_idx + IW'(1);
    end

    // Next-state: arbitrate in IDLE, serve only the owner in OWNED until unlock or hold timeout.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        q_d     = q_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    q_d     = din_arr[win_idx];
                    ack_d   = onehot(win_idx);
                    gnt_d   = onehot(win_idx);
                    owner_d = win_idx;
                    ptr_d   = ptr_nxt;
                    if (bus.lock[win_idx]) begin
                        state_d = ST_OWNED;
                        hold_d  = '0;
                    end
                end else begin
                    gnt_d = '0;
                end
            end
            default: begin
                // The owner's write goes through even on the releasing edge.
                if (bus.req[owner_q]) begin
                    q_d   = din_arr[owner_q];
                    ack_d = onehot(owner_q);
                end
                if (!bus.lock[owner_q] || (hold_q == HOLD_LAST)) begin
                    // Pointer already sits past the owner, so others win next.
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
        endcase
    end

    // State and storage registers; reset drops ownership and clears the register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            q_q     <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.q_bar = ~q_q;
    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == ST_OWNED);
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios then random traffic against a reference model.
// Outputs sampled 1ns after each rising edge; inputs change right after sampling.
// Reference model tracks owner, pointer and owned-cycle count as plain integers.
module tb_dff_bank_arbiter;
    localparam int N_REQ    = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]       req  = '0;
    logic [N_REQ-1:0]       lock = '0;
    logic [N_REQ*WIDTH-1:0] d_in = '0;

    dff_bank_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();
    assign bus.req  = req;
    assign bus.lock = lock;
    assign bus.d_in = d_in;

    dff_bank_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_q, m_gnt, m_ack, m_owner, m_ptr, m_cnt;
    bit m_owned;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q = 0; m_gnt = 0; m_ack = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_owned = 0;
    endfunction

    function automatic int din_word(input int i);
        return int'(d_in[i*WIDTH +: WIDTH]);
    endfunction

    // One clock edge of the arbiter, computed from the inputs currently applied.
    function automatic void model_edge();
        int w;
        m_ack = 0;
        if (!m_owned) begin
            w = -1;
            for (int k = 0; k < N_REQ; k++)
                if (w < 0 && req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
            if (w >= 0) begin
                m_q     = din_word(w);
                m_ack   = 1 << w;
                m_gnt   = 1 << w;
                m_owner = w;
                m_ptr   = (w + 1) % N_REQ;
                if (lock[w]) begin
                    m_owned = 1;
                    m_cnt   = 0;
                end
            end else begin
                m_gnt = 0;
            end
        end else begin
            if (req[m_owner]) begin
                m_q   = din_word(m_owner);
                m_ack = 1 << m_owner;
            end
            m_cnt++;
            if (!lock[m_owner] || m_cnt == MAX_HOLD) begin
                m_owned = 0;
                m_gnt   = 0;
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".q"},     32'(bus.q),     m_q);
        check({tag, ".q_bar"}, 32'(bus.q_bar), (~m_q) & 32'hFF);
        check({tag, ".gnt"},   32'(bus.gnt),   m_gnt);
        check({tag, ".ack"},   32'(bus.ack),   m_ack);
        check({tag, ".owner"}, 32'(bus.owner), m_owner);
        check({tag, ".busy"},  32'(bus.busy),  32'(m_owned));
        check({tag, ".gnt1h"}, 32'($countones(bus.gnt) <= 1), 1);
        check({tag, ".ack1h"}, 32'($countones(bus.ack) <= 1), 1);
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
    task automatic mid_reset(input string tag);
        #2;
        clr_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst_q"},    32'(bus.q),     32'h00);
        check({tag, ".rst_qbar"}, 32'(bus.q_bar), 32'hFF);
        check({tag, ".rst_gnt"},  32'(bus.gnt),   0);
        check({tag, ".rst_ack"},  32'(bus.ack),   0);
        check({tag, ".rst_busy"}, 32'(bus.busy),  0);
        #1;
        clr_n = 1'b1;
    endtask

    task automatic set_din(input int i, input logic [WIDTH-1:0] v);
        d_in[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        int busy_cycles;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write, then idle
        req = 4'b0010; lock = 4'b0000; set_din(1, 8'hA5);
        cycle("t2a");
        check("t2.q", 32'(bus.q), 32'hA5);
        check("t2.gnt", 32'(bus.gnt), 32'b0010);
        req = 4'b0000;
        cycle("t2b");
        check("t2.gnt0", 32'(bus.gnt), 0);
        check("t2.hold", 32'(bus.q), 32'hA5);

        // Async reset mid-cycle with a non-zero register
        mid_reset("t1");

        // Full round robin from pointer 0
        req = 4'b1111; lock = 4'b0000;
        for (int i = 0; i < N_REQ; i++) set_din(i, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) begin
            cycle("t3");
            check("t3.owner", 32'(bus.owner), i % N_REQ);
            check("t3.q", 32'(bus.q), 32'h10 + (i % N_REQ));
        end

        // Move pointer to 2, then lock by requester 2
        req = 4'b0010; lock = 4'b0000;
        cycle("t4pre");
        req = 4'b0101; lock = 4'b0100; set_din(0, 8'h33); set_din(2, 8'h44);
        cycle("t4own");
        check("t4.owner", 32'(bus.owner), 2);
        for (int i = 0; i < 3; i++) begin
            set_din(2, 8'(8'h50 + i));
            cycle("t4held");
            check("t4.noack0", 32'(bus.ack[0]), 0);
        end
        lock = 4'b0000;
        cycle("t4rel");
        cycle("t4next");
        check("t4.grant0", 32'(bus.gnt), 32'b0001);

        // Move pointer to 3, then hold timeout
        req = 4'b0100;
        cycle("t5pre");
        req = 4'b1001; lock = 4'b1001; set_din(3, 8'h77);
        cycle("t5own");
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 20) begin
            busy_cycles++;
            set_din(3, 8'($urandom));
            cycle("t5held");
        end
        check("t5.busy_cycles", 32'(busy_cycles), MAX_HOLD);
        cycle("t5next");
        check("t5.grant0", 32'(bus.gnt), 32'b0001);

        // Reset while owned, then fresh arbitration from pointer 0
        req = 4'b0001; lock = 4'b0001; set_din(0, 8'h9C);
        cycle("t6own");
        cycle("t6held");
        check("t6.busy", 32'(bus.busy), 1);
        mid_reset("t6");
        req = 4'b0100; lock = 4'b0000; set_din(2, 8'h21);
        cycle("t6after");
        check("t6.gnt", 32'(bus.gnt), 32'b0100);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            req  = 4'($urandom);
            lock = 4'($urandom) | 4'($urandom);
            d_in = 32'($urandom);
            if ($urandom_range(0, 59) == 0) mid_reset("rnd");
            else cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
